// File: rtl/adc_scan_ctrl_pkg.sv
// rtl/adc_scan_ctrl_pkg.sv - shared types and constants for the ADC scan controller
package adc_scan_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int N_CHAN = 4;
    localparam int CHAN_W = 2;
    localparam logic [DATA_W-1:0] ERR_DATA = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SOC_H,
        ST_SOC_L,
        ST_WAIT_RFD,
        ST_DAV,
        ST_REL,
        ST_NEXT
    } state_t;

    function automatic logic [N_CHAN-1:0] chan_bit(input logic [CHAN_W-1:0] c);
        return N_CHAN'(1) << c;
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// rtl/adc_scan_ctrl_if.sv - converter and consumer signal bundle of the scan controller
interface adc_scan_ctrl_if;
    import adc_scan_ctrl_pkg::*;

    logic [CHAN_W-1:0] mux_sel;
    logic              soc;
    logic              eoc;
    logic [DATA_W-1:0] x;
    logic              dav_;
    logic              rfd;
    logic [CHAN_W-1:0] chan;
    logic [DATA_W-1:0] data;
    logic              err;

    modport master (
        output mux_sel, soc, dav_, chan, data, err,
        input  eoc, x, rfd
    );

    modport slave (
        input  mux_sel, soc, dav_, chan, data, err,
        output eoc, x, rfd
    );

endinterface

// File: rtl/adc_prio_pick.sv
// rtl/adc_prio_pick.sv - lowest-set-bit encoder for the channel mask
module adc_prio_pick
    import adc_scan_ctrl_pkg::*;
(
    input  logic [N_CHAN-1:0] mask_i,
    output logic [CHAN_W-1:0] idx_o,
    output logic              any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = CHAN_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - scans enabled channels through a shared converter and
// hands each result to a consumer over a dav_/rfd handshake
module adc_scan_ctrl
    import adc_scan_ctrl_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [N_CHAN-1:0] en_mask,
    output logic              busy,
    output logic              done,
    adc_scan_ctrl_if.master   bus
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        settle_q, settle_d;
    logic [9:0]        tmo_q, tmo_d;
    logic [N_CHAN-1:0] mask_q, mask_d;
    logic [CHAN_W-1:0] sel_q, sel_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              soc_q, soc_d;
    logic              dav_n_q, dav_n_d;
    logic              done_q, done_d;

    logic [N_CHAN-1:0] remain;
    logic [N_CHAN-1:0] pick_mask;
    logic [CHAN_W-1:0] pick_idx;
    logic              pick_any;

    // One encoder serves both the initial pick and the advance to the next channel.
    assign remain    = mask_q & ~chan_bit(sel_q);
    assign pick_mask = (state_q == ST_IDLE) ? en_mask : remain;

    adc_prio_pick u_pick (
        .mask_i (pick_mask),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            chan_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            soc_q    <= 1'b0;
            dav_n_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            chan_q   <= chan_d;
            data_q   <= data_d;
            err_q    <= err_d;
            soc_q    <= soc_d;
            dav_n_q  <= dav_n_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        chan_d   = chan_q;
        data_d   = data_q;
        err_d    = err_q;
        soc_d    = soc_q;
        dav_n_d  = dav_n_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pick_any) begin
                        mask_d   = en_mask;
                        sel_d    = pick_idx;
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_CNT) begin
                    soc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_SOC_H;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SOC_H: begin
                if (!bus.eoc) begin
                    soc_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_SOC_L;
                end else if (tmo_q == TMO_LAST) begin
                    soc_d   = 1'b0;
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    chan_d  = sel_q;
                    state_d = ST_WAIT_RFD;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            ST_SOC_L: begin
                if (bus.eoc) begin
                    data_d  = bus.x;
                    err_d   = 1'b0;
                    chan_d  = sel_q;
                    state_d = ST_WAIT_RFD;
                end else if (tmo_q == TMO_LAST) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    chan_d  = sel_q;
                    state_d = ST_WAIT_RFD;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
            end
            ST_WAIT_RFD: begin
                if (bus.rfd) begin
                    dav_n_d = 1'b0;
                    state_d = ST_DAV;
                end
            end
            ST_DAV: begin
                if (!bus.rfd) begin
                    dav_n_d = 1'b1;
                    state_d = ST_REL;
                end
            end
            ST_REL: state_d = ST_NEXT;
            ST_NEXT: begin
                mask_d = remain;
                if (pick_any) begin
                    sel_d    = pick_idx;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign bus.mux_sel = sel_q;
    assign bus.soc     = soc_q;
    assign bus.dav_    = dav_n_q;
    assign bus.chan    = chan_q;
    assign bus.data    = data_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - self-checking bench for adc_scan_ctrl
module tb_adc_scan_ctrl;
    import adc_scan_ctrl_pkg::*;

    localparam int SETTLE_P  = 2;
    localparam int TIMEOUT_P = 16;

    typedef struct packed {
        logic       err;
        logic [1:0] chan;
        logic [7:0] data;
    } dlv_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] vals;
        bit          st_en;
        int          st_ch;
        int          hold;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] en_mask = 4'h0;
    logic       busy;
    logic       done;

    adc_scan_ctrl_if bus();

    adc_scan_ctrl #(.SETTLE(SETTLE_P), .TIMEOUT(TIMEOUT_P)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .en_mask (en_mask),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] conv_val [4];
    bit         stuck_en = 1'b0;
    int         stuck_ch = 0;
    int         rfd_release_cyc = 0;
    logic [3:0] exp_mask = 4'h0;
    dlv_t       got_q [$];

    // Converter: two-phase eoc handshake, optionally dead on one channel.
    initial begin : converter
        int lat, lo, ch;
        bus.eoc = 1'b1;
        bus.x   = 8'h00;
        forever begin
            @(posedge clock); #1;
            if (bus.soc && bus.eoc && !(stuck_en && int'(bus.mux_sel) == stuck_ch)) begin
                ch  = int'(bus.mux_sel);
                lat = $urandom_range(0, 2);
                repeat (lat) begin @(posedge clock); #1; end
                bus.eoc = 1'b0;
                bus.x   = 8'($urandom);
                lo = $urandom_range(1, 3);
                repeat (lo) begin @(posedge clock); #1; end
                bus.x   = conv_val[ch];
                bus.eoc = 1'b1;
            end
        end
    end

    // Consumer: records each delivery on dav_ low, then releases with random delays.
    initial begin : consumer
        int n;
        bus.rfd = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (cyc < rfd_release_cyc) begin
                bus.rfd = 1'b0;
            end else if (!bus.dav_) begin
                got_q.push_back(dlv_t'({bus.err, bus.chan, bus.data}));
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
                bus.rfd = 1'b0;
                n = 0;
                while (!bus.dav_ && n < 20) begin @(posedge clock); #1; n++; end
                repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            end else begin
                bus.rfd = 1'b1;
            end
        end
    end

    int   soc_rises = 0, dav_falls = 0, done_cnt = 0, sel_bad = 0;
    int   pb_soc = 0, pb_dav = 0, pb_hold = 0;
    int   run = 0;
    int   run_len [4] = '{0, 0, 0, 0};
    logic soc_prev = 1'b0, dav_prev = 1'b1, rfd_prev = 1'b0;
    dlv_t held = '0;
    dlv_t cur;
    assign cur = dlv_t'({bus.err, bus.chan, bus.data});

    always @(negedge clock) begin
        soc_prev <= bus.soc;
        dav_prev <= bus.dav_;
        rfd_prev <= bus.rfd;
        run      <= bus.soc ? run + 1 : 0;
        if (bus.soc && !soc_prev) soc_rises <= soc_rises + 1;
        if (!bus.soc && soc_prev) run_len[bus.mux_sel] <= run;
        if (bus.soc && !exp_mask[bus.mux_sel]) sel_bad <= sel_bad + 1;
        if (bus.soc && !busy) pb_soc <= pb_soc + 1;
        if (!bus.dav_ && dav_prev) begin
            dav_falls <= dav_falls + 1;
            held      <= cur;
            if (!rfd_prev) pb_dav <= pb_dav + 1;
        end
        if (!bus.dav_ && !dav_prev && cur != held) pb_hold <= pb_hold + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic run_scan(input string nm, input logic [3:0] m, input logic [31:0] vals,
                            input bit st_en, input int st_ch, input int hold,
                            output int n_got, output int first, output int last);
        dlv_t exp_q [$];
        int   base, r0, d0, dn0, sb0, pb0, n;
        bit   ab;
        for (int c = 0; c < 4; c++) conv_val[c] = vals[8*c +: 8];
        stuck_en = st_en;
        stuck_ch = st_ch;
        exp_mask = m;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                ab = st_en && (st_ch == c);
                exp_q.push_back(dlv_t'({ab, 2'(c), ab ? 8'h00 : vals[8*c +: 8]}));
            end
        end
        base = got_q.size();
        r0 = soc_rises; d0 = dav_falls; dn0 = done_cnt; sb0 = sel_bad;
        pb0 = pb_soc + pb_dav + pb_hold;
        rfd_release_cyc = cyc + hold;
        en_mask = m;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 1500) begin
            en_mask = 4'($urandom);
            start = busy && (n % 5 == 2);
            step();
            n++;
        end
        start = 1'b0;
        chk({nm, " scan_done"}, int'(n < 1500), 1);
        repeat (3) step();
        n_got = got_q.size() - base;
        chk({nm, " count"}, n_got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_got; i++)
            chk($sformatf("%s dlv%0d", nm, i), int'(got_q[base + i]), int'(exp_q[i]));
        first = (n_got > 0) ? int'(got_q[base].chan) : -1;
        last  = (n_got > 0) ? int'(got_q[got_q.size() - 1].chan) : -1;
        chk({nm, " soc_pulses"}, soc_rises - r0, exp_q.size());
        chk({nm, " dav_pulses"}, dav_falls - d0, exp_q.size());
        chk({nm, " done_pulses"}, done_cnt - dn0, 1);
        chk({nm, " soc_sel"}, sel_bad - sb0, 0);
        chk({nm, " protocol"}, pb_soc + pb_dav + pb_hold - pb0, 0);
        chk({nm, " idle_busy"}, int'(busy), 0);
        if (st_en && m[st_ch]) chk({nm, " abort_len"}, run_len[st_ch], TIMEOUT_P);
        stuck_en = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t       tbl [8];
        int         ng, fi, la, n;
        logic [3:0] rm;

        tbl[0] = '{4'hF, 32'h281E140A, 1'b0, 0, 0,  4,  0,  3};
        tbl[1] = '{4'hA, 32'h44332211, 1'b0, 0, 0,  2,  1,  3};
        tbl[2] = '{4'h0, 32'h00000000, 1'b0, 0, 0,  0, -1, -1};
        tbl[3] = '{4'hC, 32'h99887766, 1'b1, 2, 0,  2,  2,  3};
        tbl[4] = '{4'h1, 32'h000000A5, 1'b0, 0, 3,  1,  0,  0};
        tbl[5] = '{4'h8, 32'h5A000000, 1'b0, 0, 0,  1,  3,  3};
        tbl[6] = '{4'h5, 32'h00FF00FF, 1'b1, 0, 0,  2,  0,  2};
        tbl[7] = '{4'h6, 32'h12345678, 1'b0, 0, 20, 2,  1,  2};

        reset = 1'b1;
        repeat (3) step();
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst soc", int'(bus.soc), 0);
        chk("rst dav_", int'(bus.dav_), 1);
        chk("rst mux_sel", int'(bus.mux_sel), 0);
        chk("rst chan", int'(bus.chan), 0);
        chk("rst data", int'(bus.data), 0);
        chk("rst err", int'(bus.err), 0);
        reset = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 8; i++) begin
            run_scan($sformatf("vec%0d", i), tbl[i].mask, tbl[i].vals, tbl[i].st_en,
                     tbl[i].st_ch, tbl[i].hold, ng, fi, la);
            chk($sformatf("vec%0d n", i), ng, tbl[i].exp_n);
            chk($sformatf("vec%0d first", i), fi, tbl[i].exp_first);
            chk($sformatf("vec%0d last", i), la, tbl[i].exp_last);
        end

        for (int i = 0; i < 16; i++) begin
            rm = 4'($urandom_range(0, 15));
            run_scan($sformatf("rnd%0d", i), rm, $urandom, ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0, ng, fi, la);
        end

        // soc latency after start is sampled
        conv_val[2] = 8'h3C;
        exp_mask = 4'h4;
        en_mask = 4'h4;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!bus.soc && n < 20) begin step(); n++; end
        chk("latency", n, SETTLE_P + 1);
        chk("latency mux_sel", int'(bus.mux_sel), 2);
        n = 0;
        while (!done && n < 200) begin step(); n++; end
        chk("latency scan_done", int'(n < 200), 1);
        repeat (3) step();

        // empty mask: done on the following cycle, never busy
        en_mask = 4'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty done", int'(done), 1);
        chk("empty busy", int'(busy), 0);
        step();
        chk("empty done_end", int'(done), 0);
        repeat (2) step();

        run_scan("rfd_hold50", 4'hF, 32'hC3B2A190, 1'b0, 0, 50, ng, fi, la);

        // reset during SOC_L
        for (int c = 0; c < 4; c++) conv_val[c] = 8'(8'h50 + c);
        exp_mask = 4'hF;
        en_mask = 4'hF;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!bus.soc && n < 50) begin step(); n++; end
        n = 0;
        while (bus.soc && n < 50) begin step(); n++; end
        chk("soc_l reached", int'(n < 50 && busy), 1);
        reset = 1'b1;
        step();
        chk("soc_l rst soc", int'(bus.soc), 0);
        chk("soc_l rst dav_", int'(bus.dav_), 1);
        chk("soc_l rst busy", int'(busy), 0);
        reset = 1'b0;
        repeat (10) step();

        // reset during DAV
        en_mask = 4'hF;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (bus.dav_ && n < 200) begin step(); n++; end
        chk("dav reached", int'(n < 200), 1);
        reset = 1'b1;
        step();
        chk("dav rst soc", int'(bus.soc), 0);
        chk("dav rst dav_", int'(bus.dav_), 1);
        chk("dav rst busy", int'(busy), 0);
        reset = 1'b0;
        repeat (10) step();

        run_scan("post_reset", 4'hF, 32'h0D0C0B0A, 1'b0, 0, 0, ng, fi, la);
        chk("post_reset first", fi, 0);
        chk("post_reset last", la, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
